// File: rtl/alu_shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
// Mode codes above SH_ROR are pass-through; this is what is_shift_mode tests for.
package alu_shift_pkg;

   typedef enum logic [2:0] {
      SH_SHL = 3'b000,
      SH_SHR = 3'b001,
      SH_SAR = 3'b010,
      SH_ROL = 3'b011,
      SH_ROR = 3'b100
   } sh_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sh_state_e;

   function automatic logic is_shift_mode(input logic [2:0] m);
      return (m <= SH_ROR);
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One shift/rotate step of k (0..STEP) bit positions; purely combinational.
// Zero latency, no backpressure; the carry returned is the last bit moved out.
module alu_shift_step
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int STEP  = 1,
   localparam int KW   = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [2:0]       mode_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] next_o,
   output logic             carry_o
);

   logic signed [WIDTH-1:0] value_s;

   assign value_s = value_i;

   // Unrolled over every legal k so each bit index below is a constant.
   always_comb begin
      next_o  = value_i;
      carry_o = 1'b0;
      for (int j = 1; j <= STEP; j++) begin
         if (int'(k_i) == j) begin
            case (mode_i)
               SH_SHL: begin
                  next_o  = value_i << j;
                  carry_o = value_i[WIDTH-j];
               end
               SH_SHR: begin
                  next_o  = value_i >> j;
                  carry_o = value_i[j-1];
               end
               SH_SAR: begin
                  next_o  = value_s >>> j;
                  carry_o = value_i[j-1];
               end
               SH_ROL: begin
                  next_o  = (value_i << j) | (value_i >> (WIDTH - j));
                  carry_o = value_i[WIDTH-j];
               end
               SH_ROR: begin
                  next_o  = (value_i >> j) | (value_i << (WIDTH - j));
                  carry_o = value_i[j-1];
               end
               default: begin
                  next_o  = value_i;
                  carry_o = 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate engine with start/done handshake, STEP bits per cycle.
// Latency ceil(shamt/STEP)+1 cycles; starts are ignored while busy, accepted in IDLE or DONE.
module alu_shift_seq
   import alu_shift_pkg::*;
#(
   parameter int WIDTH   = 6,
   parameter int SHAMT_W = 3,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         mode_i,
   input  logic [WIDTH-1:0]   in_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [WIDTH-1:0]   out_o,
   output logic               carry_o,
   output logic               zero_o
);

   localparam int KW = $clog2(STEP + 1);

   sh_state_e          state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;
   logic [2:0]         mode_q, mode_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;

   logic               accept;
   logic [SHAMT_W-1:0] load_rem;
   logic [KW-1:0]      k;
   logic               last_step;
   logic [WIDTH-1:0]   step_val;
   logic               step_carry;

   assign accept    = start_i && (state_q != ST_SHIFT);
   assign load_rem  = is_shift_mode(mode_i) ? shamt_i : '0;
   assign last_step = (int'(rem_q) <= STEP);

   always_comb begin
      if (int'(rem_q) < STEP) k = KW'(rem_q);
      else                    k = KW'(STEP);
   end

   alu_shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .value_i (out_q),
      .mode_i  (mode_q),
      .k_i     (k),
      .next_o  (step_val),
      .carry_o (step_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) state_d = (load_rem == '0) ? ST_DONE : ST_SHIFT;
            else         state_d = ST_IDLE;
         end
         ST_SHIFT: if (last_step) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == ST_SHIFT);
      done_o = (state_q == ST_DONE);
   end

   // zero only moves when out is loaded, so it stays 0 out of reset.
   always_comb begin
      out_d   = out_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      if (accept) begin
         out_d   = in_i;
         carry_d = 1'b0;
         zero_d  = (in_i == '0);
         mode_d  = mode_i;
         rem_d   = load_rem;
      end else if (state_q == ST_SHIFT) begin
         out_d   = step_val;
         carry_d = step_carry;
         zero_d  = (step_val == '0);
         rem_d   = rem_q - SHAMT_W'(k);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         mode_q  <= '0;
         rem_q   <= '0;
      end else begin
         out_q   <= out_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
      end
   end

   assign out_o   = out_q;
   assign carry_o = carry_q;
   assign zero_o  = zero_q;

endmodule
